ecc_dec_pipe: RTL and testbench
===============================

// Module: ecc_dec_pipe
// PURPOSE
//  Pipelined multi-mode SECDED decoder: computes syndrome internally, corrects single errors and flags doubles.
//  Runs per-transaction modes (8,4)/(16,11)/(32,26) with valid/ready flow control and saturating error statistics.
//  Sits between the channel receive buffer and the info-bit unpacker. Supersedes the syndrome-fed checker.
// PARAMETERS
//  MAX_CODEWORD_WIDTH  32  widest codeword; modes shorter than this are LSB-aligned
//  MAX_INFO_WIDTH      26  widest info field; parity width P = MAX_CODEWORD_WIDTH-MAX_INFO_WIDTH (6)
//  CNT_WIDTH           16  width of each statistics counter
// PORTS
//  clk             in   1      clock, rising edge
//  rst             in   1      reset, asynchronous, active-low
//  in_valid        in   1      input word valid
//  in_ready        out  1      decoder can accept a word this cycle
//  in_data         in   32     received codeword, LSB-aligned
//  in_mode         in   2      00=(8,4) 01=(16,11) 10=(32,26) 11=reserved; sampled with in_data
//  out_valid       out  1      result valid
//  out_ready       in   1      downstream accepts result
//  out_data        out  32     corrected codeword; bits >= active length forced 0
//  out_num_errors  out  2      00 none, 01 single corrected, 10 uncorrectable, 11 reserved mode
//  out_err_pos     out  5      flipped bit index when out_num_errors==01, else 0
//  cnt_clr         in   1      synchronous clear of both counters
//  corr_cnt        out  CNT_WIDTH  accepted results with out_num_errors==01
//  uncorr_cnt      out  CNT_WIDTH  accepted results with out_num_errors==10
// BEHAVIOUR
//  Reset: in_ready=0 while rst low, then 1; out_valid=0, out_data=0, out_num_errors=00, out_err_pos=0,
//   counters=0; stage valids cleared, so in-flight words are dropped on reset mid-operation.
//  Handshake: input accepted when in_valid&&in_ready. Output consumed when out_valid&&out_ready.
//   Pipeline advance en = !out_valid || out_ready; in_ready = en. While stalled all stage regs hold,
//   and out_* are stable until consumed. No combinational path from in_valid to out_valid.
//  Stage 1 (on accept): register data, mode, syndrome s[P-1:0]. s[r] = XOR over j<L(mode) of H[r][j]&in_data[j].
//   L = 8/16/32 for modes 00/01/10. Bits j>=L are excluded from s and dropped from the data.
//  Stage 2: match s against H columns j<L (one-hot by code construction). Classify:
//   s==0 -> 00; s==col j -> 01, out_data = data ^ (1<<j), out_err_pos=j;
//   s!=0 with no match -> 10, out_data = data uncorrected; mode 11 -> 11, out_data = raw in_data, s ignored.
//  Latency: 2 cycles from accept to out_valid with out_ready held high; throughput 1 word/cycle.
//  Counters: update only on output handshake; saturate at all-ones. cnt_clr has priority.
//   If cnt_clr coincides with a qualifying handshake, the counter loads 1.
// STRUCTURE
//  ecc_pkg: MAX_* constants, mode enum (MODE_8_4, MODE_16_11, MODE_32_26, MODE_RSVD), L per mode,
//   H_MATRIX_1/2/3 as [P-1:0][MAX_CODEWORD_WIDTH-1:0] constants. Top row of each H is all-ones
//   over its L bits, giving overall parity. The encoder shares ecc_pkg.
//  Sub-module ecc_syndrome_calc (combinational, per-mode H select + XOR trees) instantiated in stage 1.
//   Column match, correction, classification and counters stay in ecc_dec_pipe.
// TESTING
//  1. mode 10, in_data=32'h0 -> 2 cycles later out_data=0, out_num_errors=00, counters unchanged.
//  2. mode 10, in_data=32'h0000_0020 -> out_data=0, out_num_errors=01, out_err_pos=5, corr_cnt=1.
//  3. mode 10, in_data=32'h0000_0003 -> out_data=32'h3, out_num_errors=10, uncorr_cnt=1.
//  4. mode 00, in_data=32'hFFFF_FF00 -> upper bits dropped; out_data=0, num=00. Mode 11 word -> num=11, data raw.
//  5. Stream 4 words, out_ready low 3 cycles mid-stream -> in_ready low, out_* stable, no loss/dup, order kept.
//  6. Preload corr_cnt=16'hFFFF + single error -> stays FFFF; cnt_clr with handshake -> 1; rst mid-stream -> out_valid=0.

Source files
------------

// File: rtl/ecc_pkg.sv
// Shared SECDED constants for the decoder and encoder: widths, mode encoding and per-mode H matrices.
// Column j of every H is {j[4:0], 1'b1}; row 0 is overall parity over the active length.
package ecc_pkg;

    localparam int MAX_CODEWORD_WIDTH = 32;
    localparam int MAX_INFO_WIDTH     = 26;
    localparam int P                  = MAX_CODEWORD_WIDTH - MAX_INFO_WIDTH;
    localparam int ERR_POS_WIDTH      = 5;

    typedef enum logic [1:0] {
        MODE_8_4   = 2'b00,
        MODE_16_11 = 2'b01,
        MODE_32_26 = 2'b10,
        MODE_RSVD  = 2'b11
    } ecc_mode_e;

    typedef enum logic [1:0] {
        ERR_NONE   = 2'b00,
        ERR_SINGLE = 2'b01,
        ERR_DOUBLE = 2'b10,
        ERR_RSVD   = 2'b11
    } ecc_err_e;

    localparam logic [P-1:0][MAX_CODEWORD_WIDTH-1:0] H_MATRIX_1 = {
        32'h0000_0000, 32'h0000_0000, 32'h0000_00F0,
        32'h0000_00CC, 32'h0000_00AA, 32'h0000_00FF
    };
    localparam logic [P-1:0][MAX_CODEWORD_WIDTH-1:0] H_MATRIX_2 = {
        32'h0000_0000, 32'h0000_FF00, 32'h0000_F0F0,
        32'h0000_CCCC, 32'h0000_AAAA, 32'h0000_FFFF
    };
    localparam logic [P-1:0][MAX_CODEWORD_WIDTH-1:0] H_MATRIX_3 = {
        32'hFFFF_0000, 32'hFF00_FF00, 32'hF0F0_F0F0,
        32'hCCCC_CCCC, 32'hAAAA_AAAA, 32'hFFFF_FFFF
    };

    function automatic logic [5:0] code_len(input ecc_mode_e mode);
        case (mode)
            MODE_8_4:   code_len = 6'd8;
            MODE_16_11: code_len = 6'd16;
            MODE_32_26: code_len = 6'd32;
            default:    code_len = 6'd0;
        endcase
    endfunction

    function automatic logic [MAX_CODEWORD_WIDTH-1:0] len_mask(input ecc_mode_e mode);
        case (code_len(mode))
            6'd8:    len_mask = 32'h0000_00FF;
            6'd16:   len_mask = 32'h0000_FFFF;
            6'd32:   len_mask = 32'hFFFF_FFFF;
            default: len_mask = 32'h0000_0000;
        endcase
    endfunction

    // Reserved mode yields an all-zero H, so no column can ever match.
    function automatic logic [P-1:0][MAX_CODEWORD_WIDTH-1:0] h_matrix(input ecc_mode_e mode);
        case (mode)
            MODE_8_4:   h_matrix = H_MATRIX_1;
            MODE_16_11: h_matrix = H_MATRIX_2;
            MODE_32_26: h_matrix = H_MATRIX_3;
            default:    h_matrix = '0;
        endcase
    endfunction

endpackage

// File: rtl/ecc_syndrome_calc.sv
// Combinational syndrome generator: selects the per-mode H, drops bits beyond the active length
// and reduces each H row against the data with an XOR tree.
module ecc_syndrome_calc
    import ecc_pkg::*;
(
    input  logic [MAX_CODEWORD_WIDTH-1:0] data_in,
    input  ecc_mode_e                     mode,
    output logic [P-1:0]                  syndrome,
    output logic [MAX_CODEWORD_WIDTH-1:0] data_out
);

    logic [P-1:0][MAX_CODEWORD_WIDTH-1:0] h;
    logic [MAX_CODEWORD_WIDTH-1:0]        masked;

    // Reserved-mode words pass through raw; the decoder ignores their syndrome.
    always_comb begin
        h        = h_matrix(mode);
        masked   = data_in & len_mask(mode);
        syndrome = '0;
        for (int r = 0; r < P; r++) begin
            syndrome[r] = ^(h[r] & masked);
        end
        data_out = (mode == MODE_RSVD) ? data_in : masked;
    end

endmodule

// File: rtl/ecc_dec_pipe.sv
// Two-stage multi-mode SECDED decoder with valid/ready flow control and saturating
// corrected/uncorrectable statistics counters.
module ecc_dec_pipe
    import ecc_pkg::*;
#(
    parameter int CNT_WIDTH = 16
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          in_valid,
    output logic                          in_ready,
    input  logic [MAX_CODEWORD_WIDTH-1:0] in_data,
    input  logic [1:0]                    in_mode,
    output logic                          out_valid,
    input  logic                          out_ready,
    output logic [MAX_CODEWORD_WIDTH-1:0] out_data,
    output logic [1:0]                    out_num_errors,
    output logic [ERR_POS_WIDTH-1:0]      out_err_pos,
    input  logic                          cnt_clr,
    output logic [CNT_WIDTH-1:0]          corr_cnt,
    output logic [CNT_WIDTH-1:0]          uncorr_cnt
);

    localparam logic [CNT_WIDTH-1:0] CNT_ONE = {{(CNT_WIDTH-1){1'b0}}, 1'b1};

    logic                          en;
    logic                          out_hs;
    logic [P-1:0]                  syn;
    logic [MAX_CODEWORD_WIDTH-1:0] syn_data;

    logic                          s1_valid_q, s1_valid_d;
    logic [MAX_CODEWORD_WIDTH-1:0] s1_data_q, s1_data_d;
    ecc_mode_e                     s1_mode_q, s1_mode_d;
    logic [P-1:0]                  s1_syn_q, s1_syn_d;

    logic                          out_valid_q, out_valid_d;
    logic [MAX_CODEWORD_WIDTH-1:0] out_data_q, out_data_d;
    ecc_err_e                      out_num_q, out_num_d;
    logic [ERR_POS_WIDTH-1:0]      out_pos_q, out_pos_d;
    logic [CNT_WIDTH-1:0]          corr_cnt_q, corr_cnt_d;
    logic [CNT_WIDTH-1:0]          uncorr_cnt_q, uncorr_cnt_d;

    logic [P-1:0][MAX_CODEWORD_WIDTH-1:0] h2;
    logic [P-1:0]                  col;
    logic                          hit;
    logic [ERR_POS_WIDTH-1:0]      hit_pos;
    logic [MAX_CODEWORD_WIDTH-1:0] corr_data;
    ecc_err_e                      corr_num;
    logic [ERR_POS_WIDTH-1:0]      corr_pos;

    assign en       = !out_valid_q || out_ready;
    assign in_ready = rst && en;
    assign out_hs   = out_valid_q && out_ready;

    ecc_syndrome_calc u_syndrome (
        .data_in  (in_data),
        .mode     (ecc_mode_e'(in_mode)),
        .syndrome (syn),
        .data_out (syn_data)
    );

    // Columns beyond the active length are zero, so a nonzero syndrome can only hit a live column.
    always_comb begin
        h2      = h_matrix(s1_mode_q);
        col     = '0;
        hit     = 1'b0;
        hit_pos = '0;
        for (int j = 0; j < MAX_CODEWORD_WIDTH; j++) begin
            for (int r = 0; r < P; r++) begin
                col[r] = h2[r][j];
            end
            if (!hit && s1_syn_q != '0 && col == s1_syn_q) begin
                hit     = 1'b1;
                hit_pos = 5'(j);
            end
        end

        corr_data = s1_data_q;
        corr_num  = ERR_NONE;
        corr_pos  = '0;
        if (s1_mode_q == MODE_RSVD) begin
            corr_num = ERR_RSVD;
        end else if (s1_syn_q == '0) begin
            corr_num = ERR_NONE;
        end else if (hit) begin
            corr_num  = ERR_SINGLE;
            corr_data = s1_data_q ^ (32'd1 << hit_pos);
            corr_pos  = hit_pos;
        end else begin
            corr_num = ERR_DOUBLE;
        end
    end

    always_comb begin
        s1_valid_d  = s1_valid_q;
        s1_data_d   = s1_data_q;
        s1_mode_d   = s1_mode_q;
        s1_syn_d    = s1_syn_q;
        out_valid_d = out_valid_q;
        out_data_d  = out_data_q;
        out_num_d   = out_num_q;
        out_pos_d   = out_pos_q;
        if (en) begin
            s1_valid_d  = in_valid;
            out_valid_d = s1_valid_q;
            if (in_valid) begin
                s1_data_d = syn_data;
                s1_mode_d = ecc_mode_e'(in_mode);
                s1_syn_d  = syn;
            end
            if (s1_valid_q) begin
                out_data_d = corr_data;
                out_num_d  = corr_num;
                out_pos_d  = corr_pos;
            end
        end
    end

    // Clear wins, but a result consumed in the same cycle still counts as the first event.
    always_comb begin
        corr_cnt_d   = corr_cnt_q;
        uncorr_cnt_d = uncorr_cnt_q;
        if (cnt_clr) begin
            corr_cnt_d   = (out_hs && out_num_q == ERR_SINGLE) ? CNT_ONE : '0;
            uncorr_cnt_d = (out_hs && out_num_q == ERR_DOUBLE) ? CNT_ONE : '0;
        end else if (out_hs) begin
            if (out_num_q == ERR_SINGLE && !(&corr_cnt_q)) begin
                corr_cnt_d = corr_cnt_q + CNT_ONE;
            end
            if (out_num_q == ERR_DOUBLE && !(&uncorr_cnt_q)) begin
                uncorr_cnt_d = uncorr_cnt_q + CNT_ONE;
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            s1_valid_q   <= 1'b0;
            s1_data_q    <= '0;
            s1_mode_q    <= MODE_8_4;
            s1_syn_q     <= '0;
            out_valid_q  <= 1'b0;
            out_data_q   <= '0;
            out_num_q    <= ERR_NONE;
            out_pos_q    <= '0;
            corr_cnt_q   <= '0;
            uncorr_cnt_q <= '0;
        end else begin
            s1_valid_q   <= s1_valid_d;
            s1_data_q    <= s1_data_d;
            s1_mode_q    <= s1_mode_d;
            s1_syn_q     <= s1_syn_d;
            out_valid_q  <= out_valid_d;
            out_data_q   <= out_data_d;
            out_num_q    <= out_num_d;
            out_pos_q    <= out_pos_d;
            corr_cnt_q   <= corr_cnt_d;
            uncorr_cnt_q <= uncorr_cnt_d;
        end
    end

    assign out_valid      = out_valid_q;
    assign out_data       = out_data_q;
    assign out_num_errors = out_num_q;
    assign out_err_pos    = out_pos_q;
    assign corr_cnt       = corr_cnt_q;
    assign uncorr_cnt     = uncorr_cnt_q;

endmodule

// File: tb/tb_ecc_dec_pipe.sv
// Scoreboard bench for ecc_dec_pipe: expected results are queued on accept and compared on
// every output handshake; counters are tracked by a small model checked each cycle.
module tb_ecc_dec_pipe;

    typedef struct packed {
        logic [31:0] data;
        logic [1:0]  num;
        logic [4:0]  pos;
    } exp_t;

    logic        clk;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] in_data;
    logic [1:0]  in_mode;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_data;
    logic [1:0]  out_num_errors;
    logic [4:0]  out_err_pos;
    logic        cnt_clr;
    logic [3:0]  corr_cnt;
    logic [3:0]  uncorr_cnt;

    int   nChecks = 0;
    int   nFail   = 0;
    exp_t sbQ[$];
    logic [3:0] modelCorr;
    logic [3:0] modelUncorr;
    exp_t monExp;
    logic qualCorr;
    logic qualUncorr;
    logic [31:0] streamWord;
    logic [1:0]  streamMode;

    ecc_dec_pipe #(.CNT_WIDTH(4)) dut (
        .clk            (clk),
        .rst            (rst),
        .in_valid       (in_valid),
        .in_ready       (in_ready),
        .in_data        (in_data),
        .in_mode        (in_mode),
        .out_valid      (out_valid),
        .out_ready      (out_ready),
        .out_data       (out_data),
        .out_num_errors (out_num_errors),
        .out_err_pos    (out_err_pos),
        .cnt_clr        (cnt_clr),
        .corr_cnt       (corr_cnt),
        .uncorr_cnt     (uncorr_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Every comparison in the bench funnels through here.
    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] expVal);
        nChecks++;
        if (obs !== expVal) begin
            nFail++;
            $display("[TB] FAIL %s: got %h, expected %h at %0t", tag, obs, expVal, $time);
        end
    endtask

    function automatic exp_t mkExp(input logic [31:0] d, input logic [1:0] n, input logic [4:0] p);
        exp_t e;
        e.data = d;
        e.num  = n;
        e.pos  = p;
        return e;
    endfunction

    function automatic logic [31:0] modeMask(input logic [1:0] m);
        case (m)
            2'd0:    return 32'h0000_00FF;
            2'd1:    return 32'h0000_FFFF;
            default: return 32'hFFFF_FFFF;
        endcase
    endfunction

    // Reference decoder: syndrome = {XOR of set-bit indices, overall parity}.
    function automatic exp_t refDecode(input logic [31:0] d, input logic [1:0] m);
        logic [31:0] w;
        logic [4:0]  idx;
        logic        par;
        if (m == 2'd3) return mkExp(d, 2'd3, 5'd0);
        w   = d & modeMask(m);
        par = ^w;
        idx = '0;
        for (int j = 0; j < 32; j++) if (w[j]) idx = idx ^ 5'(j);
        if (!par && idx == 5'd0) return mkExp(w, 2'd0, 5'd0);
        if (par) begin
            w[idx] = ~w[idx];
            return mkExp(w, 2'd1, idx);
        end
        return mkExp(w, 2'd2, 5'd0);
    endfunction

    // Random valid codeword in mode m with 'flips' distinct bit errors; junk above the length.
    function automatic logic [31:0] makeWord(input logic [1:0] m, input int flips);
        logic [31:0] w;
        logic [4:0]  idx;
        int          len;
        int          a;
        int          b;
        if (m == 2'd3) return $urandom;
        len = 8 << m;
        w   = $urandom & modeMask(m);
        idx = '0;
        for (int j = 0; j < 32; j++) if (w[j]) idx = idx ^ 5'(j);
        w[idx] = ~w[idx];
        if (^w) w[0] = ~w[0];
        a = $urandom_range(len - 1, 0);
        b = (a + 1 + $urandom_range(len - 2, 0)) % len;
        if (flips >= 1) w[a] = ~w[a];
        if (flips >= 2) w[b] = ~w[b];
        return w | ($urandom & ~modeMask(m));
    endfunction

    // Drives one word and pushes its expected result once the DUT accepts it.
    task automatic applyStimulus(input logic [31:0] d, input logic [1:0] m, input exp_t e);
        int waits;
        @(negedge clk);
        in_valid = 1'b1;
        in_data  = d;
        in_mode  = m;
        waits    = 0;
        while (!in_ready && waits < 50) begin
            @(negedge clk);
            waits++;
        end
        if (!in_ready) begin
            checkOutput("accept_timeout", 32'd0, 32'd1);
            in_valid = 1'b0;
            return;
        end
        sbQ.push_back(e);
        @(posedge clk);
        #1 in_valid = 1'b0;
    endtask

    task automatic waitDrain(input string tag);
        int cycles;
        cycles = 0;
        while (sbQ.size() != 0 && cycles < 100) begin
            @(posedge clk);
            #2;
            cycles++;
        end
        if (sbQ.size() != 0) checkOutput({tag, "_drain_timeout"}, 32'(sbQ.size()), 32'd0);
        @(negedge clk);
    endtask

    task automatic pulseClear();
        @(posedge clk);
        #1 cnt_clr = 1'b1;
        @(posedge clk);
        #1 cnt_clr = 1'b0;
    endtask

    // Output monitor: scoreboard pop, stall check and counter model.
    always @(negedge clk) begin
        if (!rst) begin
            modelCorr   = '0;
            modelUncorr = '0;
        end else begin
            checkOutput("corr_cnt", 32'(corr_cnt), 32'(modelCorr));
            checkOutput("uncorr_cnt", 32'(uncorr_cnt), 32'(modelUncorr));
            qualCorr   = 1'b0;
            qualUncorr = 1'b0;
            if (out_valid && !out_ready) checkOutput("stall_in_ready", 32'(in_ready), 32'd0);
            if (out_valid && out_ready) begin
                if (sbQ.size() == 0) begin
                    checkOutput("unexpected_output", 32'd1, 32'd0);
                end else begin
                    monExp = sbQ.pop_front();
                    checkOutput("out_data", out_data, monExp.data);
                    checkOutput("out_num_errors", 32'(out_num_errors), 32'(monExp.num));
                    checkOutput("out_err_pos", 32'(out_err_pos), 32'(monExp.pos));
                    qualCorr   = (monExp.num == 2'd1);
                    qualUncorr = (monExp.num == 2'd2);
                end
            end
            if (cnt_clr) begin
                modelCorr   = qualCorr ? 4'd1 : 4'd0;
                modelUncorr = qualUncorr ? 4'd1 : 4'd0;
            end else begin
                if (qualCorr && modelCorr != 4'hF) modelCorr = modelCorr + 4'd1;
                if (qualUncorr && modelUncorr != 4'hF) modelUncorr = modelUncorr + 4'd1;
            end
        end
    end

    initial begin
        #500000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        rst       = 1'b0;
        in_valid  = 1'b0;
        in_data   = '0;
        in_mode   = '0;
        out_ready = 1'b1;
        cnt_clr   = 1'b0;

        #2;
        checkOutput("rst_in_ready", 32'(in_ready), 32'd0);
        checkOutput("rst_out_valid", 32'(out_valid), 32'd0);
        checkOutput("rst_out_data", out_data, 32'd0);
        checkOutput("rst_num", 32'(out_num_errors), 32'd0);
        checkOutput("rst_pos", 32'(out_err_pos), 32'd0);
        checkOutput("rst_corr", 32'(corr_cnt), 32'd0);
        checkOutput("rst_uncorr", 32'(uncorr_cnt), 32'd0);
        repeat (3) @(posedge clk);
        #1 rst = 1'b1;
        @(negedge clk);
        checkOutput("post_rst_in_ready", 32'(in_ready), 32'd1);

        $display("[TB] clean word, mode 32/26, latency");
        applyStimulus(32'h0, 2'd2, mkExp(32'h0, 2'd0, 5'd0));
        checkOutput("latency_c1", 32'(out_valid), 32'd0);
        @(posedge clk);
        #1 checkOutput("latency_c2", 32'(out_valid), 32'd1);
        waitDrain("t1");

        $display("[TB] single error at bit 5");
        applyStimulus(32'h0000_0020, 2'd2, mkExp(32'h0, 2'd1, 5'd5));
        waitDrain("t2");
        checkOutput("t2_corr_cnt", 32'(corr_cnt), 32'd1);

        $display("[TB] double error");
        applyStimulus(32'h0000_0003, 2'd2, mkExp(32'h3, 2'd2, 5'd0));
        waitDrain("t3");
        checkOutput("t3_uncorr_cnt", 32'(uncorr_cnt), 32'd1);

        $display("[TB] short mode drops upper bits, reserved mode passes raw");
        applyStimulus(32'hFFFF_FF00, 2'd0, mkExp(32'h0, 2'd0, 5'd0));
        applyStimulus(32'hDEAD_BEEF, 2'd3, mkExp(32'hDEAD_BEEF, 2'd3, 5'd0));
        applyStimulus(32'h1234_0001, 2'd1, mkExp(32'h0, 2'd1, 5'd0));
        waitDrain("t4");

        $display("[TB] stream with output stall");
        fork
            begin
                for (int i = 0; i < 4; i++) begin
                    streamMode = 2'(i % 3);
                    streamWord = makeWord(streamMode, i % 3);
                    applyStimulus(streamWord, streamMode, refDecode(streamWord, streamMode));
                end
            end
            begin
                repeat (3) @(posedge clk);
                #1 out_ready = 1'b0;
                repeat (3) @(posedge clk);
                #1 out_ready = 1'b1;
            end
        join
        waitDrain("t5");

        $display("[TB] random stream with random backpressure");
        pulseClear();
        fork
            begin
                for (int i = 0; i < 30; i++) begin
                    streamMode = 2'($urandom_range(3, 0));
                    streamWord = makeWord(streamMode, $urandom_range(2, 0));
                    applyStimulus(streamWord, streamMode, refDecode(streamWord, streamMode));
                end
            end
            begin
                repeat (80) begin
                    @(posedge clk);
                    #1 out_ready = ($urandom_range(3, 0) != 0);
                end
                out_ready = 1'b1;
            end
        join
        out_ready = 1'b1;
        waitDrain("rand");

        $display("[TB] counter saturation and clear-with-handshake");
        pulseClear();
        for (int i = 0; i < 17; i++) begin
            applyStimulus(32'h0000_0020, 2'd2, mkExp(32'h0, 2'd1, 5'd5));
        end
        waitDrain("sat");
        checkOutput("sat_corr_cnt", 32'(corr_cnt), 32'hF);
        applyStimulus(32'h0000_0100, 2'd2, mkExp(32'h0, 2'd1, 5'd8));
        @(posedge clk);
        #1 cnt_clr = 1'b1;
        @(posedge clk);
        #1 cnt_clr = 1'b0;
        @(negedge clk);
        checkOutput("clr_hs_corr_cnt", 32'(corr_cnt), 32'd1);
        checkOutput("clr_hs_uncorr_cnt", 32'(uncorr_cnt), 32'd0);
        waitDrain("clr");

        $display("[TB] reset mid-stream");
        out_ready = 1'b0;
        applyStimulus(32'h0000_0001, 2'd2, mkExp(32'h0, 2'd1, 5'd0));
        applyStimulus(32'h0000_0006, 2'd2, mkExp(32'h6, 2'd2, 5'd0));
        @(posedge clk);
        #1 rst = 1'b0;
        #1;
        checkOutput("midrst_out_valid", 32'(out_valid), 32'd0);
        checkOutput("midrst_in_ready", 32'(in_ready), 32'd0);
        checkOutput("midrst_corr_cnt", 32'(corr_cnt), 32'd0);
        sbQ.delete();
        repeat (2) @(posedge clk);
        #1 rst = 1'b1;
        out_ready = 1'b1;
        applyStimulus(32'h8000_0000, 2'd2, mkExp(32'h0, 2'd1, 5'd31));
        waitDrain("post_rst");
        repeat (3) @(negedge clk);

        $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFail);
        $finish;
    end

endmodule
